aukv_gpr_wb_arbiter: RTL and testbench
======================================

Name: aukv_gpr_wb_arbiter

Overview:
Shares the single integer register-file write port between two writeback requesters. Requester 0 is the execute/ALU result path; requester 1 is the load/memory return path. The block sits between the writeback sources and the register file. It applies fixed priority to requester 0, with a starvation counter that forces a grant to requester 1, and registers the selected write into a one-stage write register that drives the register file.

Parameters:
MAX_WAIT, 4, conflict cycles requester 1 may lose before it is forced to win; legal range 0..255. 0 means requester 1 always wins a conflict.

Ports:
i_clk  input  1  clock
i_rstn  input  1  reset, asynchronous, active-low
i_req0_valid  input  1  requester 0 (ALU) has a write
i_req0_rd  input  5  requester 0 destination register
i_req0_data  input  32  requester 0 write data
o_req0_ready  output  1  requester 0 write accepted this cycle
i_req1_valid  input  1  requester 1 (load) has a write
i_req1_rd  input  5  requester 1 destination register
i_req1_data  input  32  requester 1 write data
o_req1_ready  output  1  requester 1 write accepted this cycle
o_we  output  1  register-file write enable (registered)
o_rd_addr  output  5  register-file write address (registered)
o_data  output  32  register-file write data (registered)
o_grant  output  2  one-hot source of the current write register content: bit0 = req0, bit1 = req1 (registered)
i_rs1_addr  input  5  read address 1, used for bypass
i_rs2_addr  input  5  read address 2, used for bypass
i_rs1_rf  input  32  register-file rs1 read data
i_rs2_rf  input  32  register-file rs2 read data
o_rs1data  output  32  rs1 operand after the bypass mux
o_rs2data  output  32  rs2 operand after the bypass mux

Behaviour:
- Single clock i_clk. Reset is asynchronous and active-low on i_rstn.
- Reset values: o_we=0, o_rd_addr=0, o_data=0, o_grant=2'b00, wait_cnt=0.
- Grant (combinational, same cycle):
  - Only req0 valid: grant req0.
  - Only req1 valid: grant req1.
  - Both valid: grant req1 if wait_cnt>=MAX_WAIT, else grant req0.
  - Neither valid: no grant.
- o_reqN_ready = i_reqN_valid & grantN. At most one ready is high per cycle. Readiness never depends on downstream state; the write port cannot stall.
- A requester holds valid, rd and data stable until it sees ready. Handshake completes on a clock edge where valid=1 and ready=1.
- wait_cnt is 8 bits:
  - Increments when req1 is valid and not granted, saturating at MAX_WAIT.
  - Clears to 0 when req1 is granted or req1 is not valid.
- Write register, updated at the edge after a grant:
  - o_we <= grant & (granted rd != 0).
  - o_rd_addr, o_data and o_grant load the granted request.
  - A write to x0 is accepted (ready=1), but o_we=0; o_rd_addr/o_data still load.
- Edge with no grant: o_we <= 0, o_grant <= 0; o_rd_addr and o_data hold their values.
- Latency: the accepting edge plus 1 cycle to o_we. The register file commits on the following edge.
- Reset mid-operation: the write register clears immediately (the pending write is dropped), wait_cnt clears, and readies go low while i_rstn=0.
- Back-to-back: one write is accepted every cycle with no bubble.

Optional Feature:
AUKV_WB_BYPASS_EN
- Defined: o_rsXdata = o_data when o_we=1 & o_rd_addr==i_rsX_addr & i_rsX_addr!=0; otherwise i_rsX_rf. This forwards the write that is in flight in the write register.
- Not defined: o_rsXdata = i_rsX_rf, a pure combinational pass-through.
- The bypass ports exist in both builds.

Test Plan:
- Reset: drive i_rstn=0 mid-write -> o_we=0, o_grant=0, o_data=0 immediately, with no clock edge needed.
- Single req0, rd=5, data=0xDEADBEEF -> o_req0_ready=1 the same cycle; next cycle o_we=1, o_rd_addr=5, o_data=0xDEADBEEF, o_grant=01.
- Both valid continuously, MAX_WAIT=4 -> req0 granted for 4 cycles, req1 granted on the 5th cycle (o_grant=10 one cycle later); after that grant wait_cnt=0 and req0 wins again.
- req1 write to rd=0, data=0x1234 -> o_req1_ready=1; next cycle o_we=0, o_grant=10.
- Bypass: o_we=1, o_rd_addr=7, o_data=0xA5A5A5A5, i_rs1_addr=7, i_rs1_rf=0x0 -> o_rs1data=0xA5A5A5A5 with AUKV_WB_BYPASS_EN defined, 0x0 without it. With i_rs2_addr=0 -> o_rs2data=i_rs2_rf in both builds.
- MAX_WAIT=0, both valid -> req1 granted every conflict cycle and req0 ready stays 0 until req1 drops valid.

Source files
------------

// File: rtl/aukv_gpr_wb_arbiter.sv
// rtl/aukv_gpr_wb_arbiter.sv - writeback arbiter for the shared integer register-file write port
//
// Purpose:
//   Two writeback sources share one register-file write port:
//     requester 0 - execute/ALU result path (fixed priority)
//     requester 1 - load/memory return path (protected by a starvation counter)
//   The granted write is captured in a single write register that drives the
//   register file. Acceptance never depends on downstream state; the write
//   port cannot stall.
//
// Parameters:
//   MAX_WAIT  conflict cycles requester 1 may lose before it is forced to win
//             (0..255; 0 = requester 1 always wins a conflict)
//
// Build option:
//   AUKV_WB_BYPASS_EN  when defined, the rs1/rs2 operand muxes forward the write
//                      held in the write register; when undefined they pass the
//                      register-file read data straight through.
//
// Ports:
//   i_clk, i_rstn                     clock, asynchronous active-low reset
//   i_req0_valid/rd/data, o_req0_ready requester 0 (ALU) write handshake
//   i_req1_valid/rd/data, o_req1_ready requester 1 (load) write handshake
//   o_we, o_rd_addr, o_data           registered register-file write
//   o_grant                           registered one-hot source of the write register
//   i_rs1_addr, i_rs2_addr            operand read addresses
//   i_rs1_rf, i_rs2_rf                register-file read data
//   o_rs1data, o_rs2data              operands after the bypass mux

module aukv_gpr_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,

    input  logic        i_req0_valid,
    input  logic [4:0]  i_req0_rd,
    input  logic [31:0] i_req0_data,
    output logic        o_req0_ready,

    input  logic        i_req1_valid,
    input  logic [4:0]  i_req1_rd,
    input  logic [31:0] i_req1_data,
    output logic        o_req1_ready,

    output logic        o_we,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_data,
    output logic [1:0]  o_grant,

    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic [31:0] i_rs1_rf,
    input  logic [31:0] i_rs2_rf,
    output logic [31:0] o_rs1data,
    output logic [31:0] o_rs2data
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // Consecutive conflict cycles requester 1 has lost.
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;

    logic        force1;
    logic        grant0;
    logic        grant1;
    logic        any_grant;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // Grant selection: requester 0 wins conflicts until requester 1 has lost
    // MAX_WAIT of them in a row. With MAX_WAIT=0 force1 is always true.
    always_comb begin
        force1    = (wait_cnt >= MAX_WAIT_C);
        grant1    = i_req1_valid & (~i_req0_valid | force1);
        grant0    = i_req0_valid & ~grant1;
        any_grant = grant0 | grant1;
        sel_rd    = grant1 ? i_req1_rd   : i_req0_rd;
        sel_data  = grant1 ? i_req1_data : i_req0_data;
    end

    // Readies are masked while reset is asserted so no handshake can complete
    // against a write register that is being cleared.
    assign o_req0_ready = grant0 & i_rstn;
    assign o_req1_ready = grant1 & i_rstn;

    // Starvation counter: counts only while requester 1 is waiting and losing.
    // Saturation is belt-and-braces: once the count reaches MAX_WAIT the next
    // conflict is granted to requester 1, which clears it.
    always_comb begin
        wait_cnt_nxt = 8'd0;
        if (i_req1_valid && !grant1) begin
            wait_cnt_nxt = (wait_cnt < MAX_WAIT_C) ? (wait_cnt + 8'd1) : wait_cnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Write register. A write to x0 is still accepted and its address/data
    // are captured, but the write enable stays low. With no grant the
    // address/data hold so the register file sees stable inputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_we      <= 1'b0;
            o_rd_addr <= 5'd0;
            o_data    <= 32'd0;
            o_grant   <= 2'b00;
        end else if (any_grant) begin
            o_we      <= (sel_rd != 5'd0);
            o_rd_addr <= sel_rd;
            o_data    <= sel_data;
            o_grant   <= {grant1, grant0};
        end else begin
            o_we      <= 1'b0;
            o_grant   <= 2'b00;
        end
    end

`ifdef AUKV_WB_BYPASS_EN
    // Forward the write sitting in the write register; the register file has
    // not committed it yet. x0 always reads from the register file.
    assign o_rs1data = (o_we && (o_rd_addr == i_rs1_addr) && (i_rs1_addr != 5'd0))
                       ? o_data : i_rs1_rf;
    assign o_rs2data = (o_we && (o_rd_addr == i_rs2_addr) && (i_rs2_addr != 5'd0))
                       ? o_data : i_rs2_rf;
`else
    assign o_rs1data = i_rs1_rf;
    assign o_rs2data = i_rs2_rf;

    // Read addresses only matter when forwarding is built in.
    logic unused_rs_addr;
    assign unused_rs_addr = ^{i_rs1_addr, i_rs2_addr};
`endif

endmodule

// File: tb/tb_aukv_gpr_wb_arbiter.sv
// tb/tb_aukv_gpr_wb_arbiter.sv - self-checking bench for aukv_gpr_wb_arbiter

module tb_aukv_gpr_wb_arbiter;

    localparam int MW = 4;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_req0_valid, i_req1_valid;
    logic [4:0]  i_req0_rd, i_req1_rd;
    logic [31:0] i_req0_data, i_req1_data;
    logic        o_req0_ready, o_req1_ready;
    logic        o_we;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_data;
    logic [1:0]  o_grant;
    logic [4:0]  i_rs1_addr, i_rs2_addr;
    logic [31:0] i_rs1_rf, i_rs2_rf;
    logic [31:0] o_rs1data, o_rs2data;

    // Second instance with MAX_WAIT=0, sharing all inputs.
    logic        z_req0_ready, z_req1_ready, z_we;
    logic [4:0]  z_rd_addr;
    logic [31:0] z_data, z_rs1data, z_rs2data;
    logic [1:0]  z_grant;

    always #5 i_clk = ~i_clk;

    aukv_gpr_wb_arbiter #(.MAX_WAIT(MW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_req0_valid(i_req0_valid), .i_req0_rd(i_req0_rd), .i_req0_data(i_req0_data),
        .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_rd(i_req1_rd), .i_req1_data(i_req1_data),
        .o_req1_ready(o_req1_ready),
        .o_we(o_we), .o_rd_addr(o_rd_addr), .o_data(o_data), .o_grant(o_grant),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_rf(i_rs1_rf), .i_rs2_rf(i_rs2_rf),
        .o_rs1data(o_rs1data), .o_rs2data(o_rs2data)
    );

    aukv_gpr_wb_arbiter #(.MAX_WAIT(0)) dut_z (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_req0_valid(i_req0_valid), .i_req0_rd(i_req0_rd), .i_req0_data(i_req0_data),
        .o_req0_ready(z_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_rd(i_req1_rd), .i_req1_data(i_req1_data),
        .o_req1_ready(z_req1_ready),
        .o_we(z_we), .o_rd_addr(z_rd_addr), .o_data(z_data), .o_grant(z_grant),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_rf(i_rs1_rf), .i_rs2_rf(i_rs2_rf),
        .o_rs1data(z_rs1data), .o_rs2data(z_rs2data)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: the write register contents and the number of
    // consecutive conflicts requester 1 has lost.
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [1:0]  m_grant;
    int          losses;
    logic        g0, g1;

    task automatic model_reset();
        m_we = 0; m_rd = 0; m_data = 0; m_grant = 0; losses = 0;
    endtask

    task automatic model_eval();
        g1 = i_req1_valid && (!i_req0_valid || losses >= MW);
        g0 = i_req0_valid && !g1;
    endtask

    task automatic model_commit();
        if (g0 || g1) begin
            m_rd    = g1 ? i_req1_rd : i_req0_rd;
            m_data  = g1 ? i_req1_data : i_req0_data;
            m_we    = (m_rd != 0);
            m_grant = g1 ? 2'b10 : 2'b01;
        end else begin
            m_we    = 0;
            m_grant = 0;
        end
        if (i_req1_valid && !g1) losses = (losses + 1 > MW) ? MW : losses + 1;
        else losses = 0;
    endtask

    function automatic logic [31:0] exp_byp(input logic [4:0] a, input logic [31:0] rf);
`ifdef AUKV_WB_BYPASS_EN
        if (m_we && m_rd == a && a != 0) return m_data;
`endif
        return rf;
    endfunction

    task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
        i_req0_valid = v0; i_req0_rd = rd0; i_req0_data = d0;
        i_req1_valid = v1; i_req1_rd = rd1; i_req1_data = d1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    typedef struct {
        logic        v0; logic [4:0] rd0; logic [31:0] d0;
        logic        v1; logic [4:0] rd1; logic [31:0] d1;
        logic        r0; logic r1;
        logic        we; logic [4:0] rd; logic [31:0] data; logic [1:0] gnt;
    } vec_t;

    vec_t tbl[10];

    logic        p0v, p1v;
    logic [4:0]  p0rd, p1rd;
    logic [31:0] p0d, p1d;

    initial begin
        // v0 rd0 d0 | v1 rd1 d1 | r0 r1 | we rd data grant (after the edge)
        tbl[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    1, 0, 1, 5'd5, 32'hDEADBEEF, 2'b01};
        tbl[1] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 0, 1, 0, 5'd0, 32'h1234,     2'b10};
        tbl[2] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 5'd0, 32'h1234,     2'b00};
        tbl[3] = '{0, 5'd0, 32'h0,        1, 5'd3, 32'h33,   0, 1, 1, 5'd3, 32'h33,       2'b10};
        tbl[4] = '{1, 5'd1, 32'h11,       1, 5'd2, 32'h22,   1, 0, 1, 5'd1, 32'h11,       2'b01};
        tbl[5] = '{1, 5'd1, 32'h12,       1, 5'd2, 32'h22,   1, 0, 1, 5'd1, 32'h12,       2'b01};
        tbl[6] = '{1, 5'd1, 32'h13,       1, 5'd2, 32'h22,   1, 0, 1, 5'd1, 32'h13,       2'b01};
        tbl[7] = '{1, 5'd1, 32'h14,       1, 5'd2, 32'h22,   1, 0, 1, 5'd1, 32'h14,       2'b01};
        tbl[8] = '{1, 5'd1, 32'h15,       1, 5'd2, 32'h22,   0, 1, 1, 5'd2, 32'h22,       2'b10};
        tbl[9] = '{1, 5'd1, 32'h15,       1, 5'd4, 32'h44,   1, 0, 1, 5'd1, 32'h15,       2'b01};

        i_rstn = 0;
        drive(0, 0, 0, 0, 0, 0);
        i_rs1_addr = 0; i_rs2_addr = 0; i_rs1_rf = 0; i_rs2_rf = 0;
        model_reset();
        tick(); tick();
        chk("reset_we",    o_we, 0);
        chk("reset_rd",    o_rd_addr, 0);
        chk("reset_data",  o_data, 0);
        chk("reset_grant", o_grant, 0);
        i_rstn = 1;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1);
            #2;
            chk($sformatf("tbl%0d_r0", i), o_req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_r1", i), o_req1_ready, tbl[i].r1);
            tick();
            chk($sformatf("tbl%0d_we", i),   o_we, tbl[i].we);
            chk($sformatf("tbl%0d_rd", i),   o_rd_addr, tbl[i].rd);
            chk($sformatf("tbl%0d_data", i), o_data, tbl[i].data);
            chk($sformatf("tbl%0d_gnt", i),  o_grant, tbl[i].gnt);
        end

        // Reset asserted while a write sits in the write register.
        drive(1, 5'd9, 32'hCAFE, 0, 0, 0);
        tick();
        chk("rst_pre_we", o_we, 1);
        i_rstn = 0;
        #1;
        chk("rst_async_we",    o_we, 0);
        chk("rst_async_grant", o_grant, 0);
        chk("rst_async_data",  o_data, 0);
        chk("rst_async_rd",    o_rd_addr, 0);
        chk("rst_ready_low",   o_req0_ready, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        i_rstn = 1;
        model_reset();

        // Bypass of the in-flight write; rs2 reads x0.
        drive(1, 5'd7, 32'hA5A5A5A5, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        i_rs1_addr = 5'd7; i_rs1_rf = 32'h0;
        i_rs2_addr = 5'd0; i_rs2_rf = 32'h5555AAAA;
        #1;
        chk("byp_we", o_we, 1);
`ifdef AUKV_WB_BYPASS_EN
        chk("byp_rs1", o_rs1data, 32'hA5A5A5A5);
`else
        chk("byp_rs1", o_rs1data, 32'h0);
`endif
        chk("byp_rs2_x0", o_rs2data, 32'h5555AAAA);
        tick();
        i_rstn = 0;
        tick();
        i_rstn = 1;
        model_reset();

        // Randomized traffic against the reference model.
        p0v = 0; p1v = 0; p0rd = 0; p1rd = 0; p0d = 0; p1d = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!p0v && $urandom_range(0, 3) != 0) begin
                p0v = 1; p0rd = 5'($urandom_range(0, 31)); p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 2) != 0) begin
                p1v = 1; p1rd = 5'($urandom_range(0, 31)); p1d = $urandom;
            end
            drive(p0v, p0rd, p0d, p1v, p1rd, p1d);
            i_rs1_addr = ($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 31));
            i_rs2_addr = ($urandom_range(0, 1) != 0) ? m_rd : 5'($urandom_range(0, 31));
            i_rs1_rf = $urandom; i_rs2_rf = $urandom;
            model_eval();
            #2;
            chk("rnd_r0", o_req0_ready, g0);
            chk("rnd_r1", o_req1_ready, g1);
            chk("rnd_z_r0", z_req0_ready, i_req0_valid && !i_req1_valid);
            chk("rnd_z_r1", z_req1_ready, i_req1_valid);
            chk("rnd_rs1", o_rs1data, exp_byp(i_rs1_addr, i_rs1_rf));
            chk("rnd_rs2", o_rs2data, exp_byp(i_rs2_addr, i_rs2_rf));
            tick();
            model_commit();
            if (g0) p0v = 0;
            if (g1) p1v = 0;
            chk("rnd_we",   o_we, m_we);
            chk("rnd_rd",   o_rd_addr, m_rd);
            chk("rnd_data", o_data, m_data);
            chk("rnd_gnt",  o_grant, m_grant);
        end

        // MAX_WAIT=0: requester 1 wins every conflict until it drops valid.
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'd6, 32'h66, 1, 5'd8, 32'h80 + c);
            #2;
            chk("mw0_r0", z_req0_ready, 0);
            chk("mw0_r1", z_req1_ready, 1);
            tick();
            chk("mw0_gnt", z_grant, 2'b10);
        end
        drive(1, 5'd6, 32'h66, 0, 0, 0);
        #2;
        chk("mw0_r0_after", z_req0_ready, 1);
        tick();
        chk("mw0_gnt_after", z_grant, 2'b01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
